// File: rtl/hub75_array_scanner.sv
// rtl/hub75_array_scanner.sv - shared HUB75 row/plane scan engine driving NUM_PANELS parallel RGB lanes
// Optional feature macro: HUB75_TEST_PATTERN_EN (adds test_mode column-gradient source)
module hub75_array_scanner #(
  parameter int NUM_PANELS = 9,
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 5,
  parameter int BPC        = 8,
  parameter int UNIT       = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [7:0]                  brightness,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        buf_sel,
  output logic                        frame_start,
  output logic [ROW_BITS-1:0]         rd_row,
  output logic [$clog2(COLS)-1:0]     rd_col,
  output logic [$clog2(BPC):0]        rd_plane,
  input  logic [6*NUM_PANELS-1:0]     rd_data,
`ifdef HUB75_TEST_PATTERN_EN
  input  logic                        test_mode,
`endif
  output logic [6*NUM_PANELS-1:0]     panel_rgb,
  output logic [ROW_BITS-1:0]         panel_addr,
  output logic                        panel_clk,
  output logic                        panel_lat,
  output logic                        panel_oe
);

  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = $clog2(BPC) + 1;
  localparam int LANE_W  = 6 * NUM_PANELS;
  localparam int LEN_W   = $clog2(UNIT) + BPC;
  localparam int PROD_W  = LEN_W + 8;
  localparam int SHIFT_W = $clog2(2 * COLS + 1);
  localparam int CNT_W   = (LEN_W > SHIFT_W) ? LEN_W : SHIFT_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PLANE_W-1:0]  plane_q, plane_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LEN_W-1:0]    on_q, on_d;
  logic                buf_sel_q, buf_sel_d;
  logic                swap_ack_q, swap_ack_d;
  logic                frame_start_q, frame_start_d;
  logic [LANE_W-1:0]   panel_rgb_q, panel_rgb_d;
  logic [ROW_BITS-1:0] panel_addr_q, panel_addr_d;
  logic                panel_clk_q, panel_clk_d;
  logic                panel_lat_q, panel_lat_d;
  logic                panel_oe_q, panel_oe_d;

  logic [LEN_W-1:0]    disp_len;
  logic [PROD_W-1:0]   on_prod;
  logic [LEN_W-1:0]    on_new;
  logic [CNT_W-1:0]    disp_last;
  logic                plane_last;
  logic                row_last;
  logic [LANE_W-1:0]   lane_src;

  // Plane on-time scales the plane's BCM slot by brightness/256.
  assign disp_len   = LEN_W'(UNIT) << plane_q;
  assign on_prod    = PROD_W'(disp_len) * PROD_W'(brightness);
  assign on_new     = on_prod[PROD_W-1:8];
  assign disp_last  = CNT_W'(disp_len) - 1'b1;
  assign plane_last = (plane_q == PLANE_W'(BPC - 1));
  assign row_last   = &row_q;

`ifdef HUB75_TEST_PATTERN_EN
  logic [COL_W-1:0] col_shifted;
  assign col_shifted = col_q >> plane_q;
  assign lane_src    = test_mode ? {LANE_W{col_shifted[0]}} : rd_data;
`else
  assign lane_src = rd_data;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    plane_d      = plane_q;
    col_d        = col_q;
    on_d         = on_q;
    buf_sel_d    = buf_sel_q;
    swap_ack_d   = 1'b0;
    panel_rgb_d  = panel_rgb_q;
    panel_addr_d = panel_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          col_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(2 * COLS)) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // Odd counts are pixel phase0: capture the prefetched word, advance the read column.
        if (cnt_q[0]) begin
          panel_rgb_d = lane_src;
          col_d       = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (cnt_q == '0) begin
          cnt_d        = cnt_q + 1'b1;
          panel_addr_d = row_q;
        end else begin
          state_d = ST_DISPLAY;
          cnt_d   = '0;
          on_d    = on_new;
        end
      end
      ST_DISPLAY: begin
        if (cnt_q == disp_last) begin
          state_d = enable ? ST_SHIFT : ST_IDLE;
          cnt_d   = '0;
          col_d   = '0;
          if (plane_last) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Swap lands on the frame's final DISPLAY cycle so the next frame reads the new buffer.
    if ((state_d == ST_DISPLAY) && (cnt_d == disp_last) && plane_last && row_last && swap_req) begin
      buf_sel_d  = ~buf_sel_q;
      swap_ack_d = 1'b1;
    end
  end

  // Pin strobes are registered from next-state so they stay aligned with state_q and glitch-free.
  always_comb begin
    frame_start_d = (state_d == ST_SHIFT) && (cnt_d == '0) && (row_d == '0) && (plane_d == '0);
    panel_clk_d   = (state_d == ST_SHIFT) && (cnt_d != '0) && !cnt_d[0];
    panel_lat_d   = (state_d == ST_LATCH) && (cnt_d == '0);
    panel_oe_d    = !((state_d == ST_DISPLAY) && (CNT_W'(on_d) > cnt_d));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      col_q         <= '0;
      on_q          <= '0;
      buf_sel_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      panel_rgb_q   <= '0;
      panel_addr_q  <= '0;
      panel_clk_q   <= 1'b0;
      panel_lat_q   <= 1'b0;
      panel_oe_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      col_q         <= col_d;
      on_q          <= on_d;
      buf_sel_q     <= buf_sel_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
      panel_rgb_q   <= panel_rgb_d;
      panel_addr_q  <= panel_addr_d;
      panel_clk_q   <= panel_clk_d;
      panel_lat_q   <= panel_lat_d;
      panel_oe_q    <= panel_oe_d;
    end
  end

  assign swap_ack    = swap_ack_q;
  assign buf_sel     = buf_sel_q;
  assign frame_start = frame_start_q;
  assign rd_row      = row_q;
  assign rd_col      = col_q;
  assign rd_plane    = plane_q;
  assign panel_rgb   = panel_rgb_q;
  assign panel_addr  = panel_addr_q;
  assign panel_clk   = panel_clk_q;
  assign panel_lat   = panel_lat_q;
  assign panel_oe    = panel_oe_q;

endmodule

// File: tb/tb_hub75_array_scanner.sv
// tb/tb_hub75_array_scanner.sv - self-checking bench for hub75_array_scanner (small 2-panel array)
module tb_hub75_array_scanner;

  localparam int NP = 2, COLS = 4, RB = 1, BPC = 2, UNIT = 4;

  logic        clock, resetn, enable, swap_req;
  logic [7:0]  brightness;
  logic        swap_ack, buf_sel, frame_start;
  logic [0:0]  rd_row;
  logic [1:0]  rd_col;
  logic [1:0]  rd_plane;
  logic [11:0] rd_data;
  logic [11:0] panel_rgb;
  logic [0:0]  panel_addr;
  logic        panel_clk, panel_lat, panel_oe;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] fixed_word = 12'h000;
  bit          pat_mode = 0;
  bit          sb_en = 0;
  logic [11:0] sb_q[$];

  hub75_array_scanner #(.NUM_PANELS(NP), .COLS(COLS), .ROW_BITS(RB), .BPC(BPC), .UNIT(UNIT)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .brightness(brightness),
    .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel), .frame_start(frame_start),
    .rd_row(rd_row), .rd_col(rd_col), .rd_plane(rd_plane), .rd_data(rd_data),
`ifdef HUB75_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .panel_rgb(panel_rgb), .panel_addr(panel_addr), .panel_clk(panel_clk),
    .panel_lat(panel_lat), .panel_oe(panel_oe)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [11:0] fb_word(input logic b, input logic r, input logic [1:0] c,
                                          input logic [1:0] p);
    logic [5:0] lane0;
    lane0 = {b, r, c, p};
    return {lane0 ^ 6'b101101, lane0};
  endfunction

  // Frame buffer: word for the address seen this cycle is presented one cycle later.
  initial begin : fb_model
    logic [11:0] nxt;
    rd_data = '0;
    forever begin
      @(negedge clock);
      nxt = pat_mode ? fb_word(buf_sel, rd_row[0], rd_col, rd_plane) : fixed_word;
      @(posedge clock);
      #1 rd_data = nxt;
    end
  end

  initial begin : pin_monitor
    logic pclk_p, oe_p, rst_p;
    logic [0:0] addr_p;
    logic [11:0] exp;
    pclk_p = 1'b0; oe_p = 1'b1; rst_p = 1'b0; addr_p = '0;
    forever begin
      @(negedge clock);
      if (panel_lat) begin
        vectors++;
        if (panel_oe !== 1'b1) begin
          miscompares++;
          $display("FAIL lat_oe_exclusive: panel_oe=%b while panel_lat=1, required 1", panel_oe);
        end
      end
      if (resetn && rst_p && (panel_addr !== addr_p)) begin
        vectors++;
        if (!(panel_oe && oe_p)) begin
          miscompares++;
          $display("FAIL addr_change_blanked: oe before/after=%b/%b, required 1/1", oe_p, panel_oe);
        end
      end
      if (sb_en && panel_clk && !pclk_p) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_underflow: unexpected panel_clk edge, rgb=%h", panel_rgb);
        end else begin
          exp = sb_q.pop_front();
          if (panel_rgb !== exp) begin
            miscompares++;
            $display("FAIL sb_rgb: got %h required %h", panel_rgb, exp);
          end
        end
      end
      pclk_p = panel_clk; oe_p = panel_oe; rst_p = resetn; addr_p = panel_addr;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_frame_start();
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (!frame_start && t < 200);
    vectors++;
    if (!frame_start) begin
      miscompares++;
      $display("FAIL frame_start_timeout: none within %0d cycles", t);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; swap_req = 1'b0; brightness = 8'd128; fixed_word = 12'hA5C;
    repeat (3) tick();
    vectors++;
    if ({panel_oe, panel_clk, panel_lat, frame_start, swap_ack, buf_sel} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 100000",
               {panel_oe, panel_clk, panel_lat, frame_start, swap_ack, buf_sel});
    end
    vectors++;
    if ({panel_addr, rd_row, rd_col, rd_plane} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_addr: got %b required 0", {panel_addr, rd_row, rd_col, rd_plane});
    end
    vectors++;
    if (panel_rgb !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_rgb: got %h required 000", panel_rgb);
    end
    @(negedge clock);
    resetn = 1'b1;
    repeat (5) tick();
    vectors++;
    if (panel_oe !== 1'b1 || frame_start !== 1'b0 || panel_clk !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_disabled: oe=%b fs=%b clk=%b required 1/0/0", panel_oe, frame_start, panel_clk);
    end
  endtask

  task automatic test_shift_latch();
    int fs_cnt, fs_k, clk_rise, lat_cyc, first_lat, oe0, oe1;
    logic pclk_p;
    logic [11:0] rgb2, rgb3;
    fs_cnt = 0; fs_k = -1; clk_rise = 0; lat_cyc = 0; first_lat = -1; oe0 = 0; oe1 = 0;
    rgb2 = 'x; rgb3 = 'x;
    pclk_p = panel_clk;
    enable = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (frame_start) begin fs_cnt++; if (fs_k < 0) fs_k = k; end
      if (k <= 9 && panel_clk && !pclk_p) clk_rise++;
      pclk_p = panel_clk;
      if (k <= 15 && panel_lat) begin lat_cyc++; if (first_lat < 0) first_lat = k; end
      if (!panel_oe) begin if (k <= 15) oe0++; else oe1++; end
      if (k == 2) rgb2 = panel_rgb;
      if (k == 3) rgb3 = panel_rgb;
    end
    vectors++;
    if (fs_cnt !== 1 || fs_k !== 1) begin
      miscompares++;
      $display("FAIL first_frame_start: count=%0d cycle=%0d required 1/1", fs_cnt, fs_k);
    end
    vectors++;
    if (clk_rise !== 4) begin
      miscompares++;
      $display("FAIL shift_clk_edges: got %0d required 4", clk_rise);
    end
    vectors++;
    if (lat_cyc !== 1 || first_lat !== 10) begin
      miscompares++;
      $display("FAIL latch_pulse: cycles=%0d at=%0d required 1 at 10", lat_cyc, first_lat);
    end
    vectors++;
    if (rgb2 !== 12'h000) begin
      miscompares++;
      $display("FAIL rgb_before_phase0: got %h required 000", rgb2);
    end
    vectors++;
    if (rgb3 !== 12'hA5C) begin
      miscompares++;
      $display("FAIL rgb_after_phase0: got %h required a5c", rgb3);
    end
    vectors++;
    if (rgb3[11:6] !== 6'b101001) begin
      miscompares++;
      $display("FAIL lane1_bits: got %b required 101001", rgb3[11:6]);
    end
    vectors++;
    if (oe0 !== 2) begin
      miscompares++;
      $display("FAIL plane0_on_time: got %0d required 2", oe0);
    end
    vectors++;
    if (oe1 !== 4) begin
      miscompares++;
      $display("FAIL plane1_on_time: got %0d required 4", oe1);
    end
  endtask

  task automatic test_brightness_zero();
    int oe_low;
    oe_low = 0;
    wait_frame_start();
    brightness = 8'd0;
    for (int k = 1; k <= 68; k++) begin
      tick();
      if (!panel_oe) oe_low++;
    end
    vectors++;
    if (oe_low !== 0) begin
      miscompares++;
      $display("FAIL brightness_zero: oe low %0d cycles, required 0", oe_low);
    end
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_period: frame_start=%b 68 cycles later, required 1", frame_start);
    end
    brightness = 8'd128;
  endtask

  task automatic test_scoreboard_frame();
    wait_frame_start();
    pat_mode = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < BPC; p++)
        for (int c = 0; c < COLS; c++)
          sb_q.push_back(fb_word(1'b0, r[0], c[1:0], p[1:0]));
    sb_en = 1'b1;
    wait_frame_start();
    sb_en = 1'b0;
    vectors++;
    if (sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d entries not seen, required 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_swap();
    int t, acks;
    logic exp_buf;
    exp_buf = 1'b0;
    wait_frame_start();
    repeat (20) tick();
    swap_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      t = 0;
      while (!swap_ack && t < 100) begin tick(); t++; end
      exp_buf = ~exp_buf;
      vectors++;
      if (t !== ((n == 0) ? 47 : 67)) begin
        miscompares++;
        $display("FAIL swap_ack_timing[%0d]: after %0d cycles, required %0d", n, t, (n == 0) ? 47 : 67);
      end
      vectors++;
      if (buf_sel !== exp_buf) begin
        miscompares++;
        $display("FAIL buf_sel_toggle[%0d]: got %b required %b", n, buf_sel, exp_buf);
      end
      if (n == 2) swap_req = 1'b0;
      tick();
      vectors++;
      if (frame_start !== 1'b1 || swap_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL post_swap_frame[%0d]: fs=%b ack=%b required 1/0", n, frame_start, swap_ack);
      end
    end
    acks = 0;
    repeat (80) begin tick(); if (swap_ack) acks++; end
    vectors++;
    if (acks !== 0 || buf_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL swap_released: acks=%0d buf=%b required 0/1", acks, buf_sel);
    end
  endtask

  task automatic test_pause_resume();
    int oe_low;
    bit idle_ok, fs_seen;
    wait_frame_start();
    repeat (36) tick();
    enable = 1'b0;
    oe_low = 0;
    for (int k = 37; k <= 48; k++) begin tick(); if (!panel_oe) oe_low++; end
    vectors++;
    if (oe_low !== 2) begin
      miscompares++;
      $display("FAIL pause_finishes_display: oe low %0d, required 2", oe_low);
    end
    idle_ok = 1; fs_seen = 0;
    for (int k = 49; k <= 58; k++) begin
      tick();
      if (panel_oe !== 1'b1 || panel_clk !== 1'b0 || panel_lat !== 1'b0) idle_ok = 0;
      if (frame_start) fs_seen = 1;
    end
    vectors++;
    if (!idle_ok || fs_seen) begin
      miscompares++;
      $display("FAIL paused_idle: quiet=%0d fs_seen=%0d required 1/0", idle_ok, fs_seen);
    end
    vectors++;
    if (rd_row !== 1'b1 || rd_plane !== 2'd1) begin
      miscompares++;
      $display("FAIL paused_position: row=%0d plane=%0d required 1/1", rd_row, rd_plane);
    end
    enable = 1'b1;
    tick();
    vectors++;
    if (frame_start !== 1'b0 || rd_row !== 1'b1 || rd_plane !== 2'd1 || rd_col !== 2'd0) begin
      miscompares++;
      $display("FAIL resume_position: fs=%b row=%0d plane=%0d col=%0d required 0/1/1/0",
               frame_start, rd_row, rd_plane, rd_col);
    end
    oe_low = 0;
    repeat (18) begin tick(); if (!panel_oe) oe_low++; end
    vectors++;
    if (oe_low !== 4) begin
      miscompares++;
      $display("FAIL resume_plane1_on: oe low %0d, required 4", oe_low);
    end
    tick();
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL resume_next_frame: frame_start=%b required 1", frame_start);
    end
  endtask

  task automatic test_reset_mid_display();
    repeat (46) tick();
    vectors++;
    if (panel_oe !== 1'b0 || panel_addr !== 1'b1 || buf_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_state: oe=%b addr=%b buf=%b required 0/1/1", panel_oe, panel_addr, buf_sel);
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (panel_oe !== 1'b1 || panel_addr !== 1'b0 || buf_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: oe=%b addr=%b buf=%b required 1/0/0", panel_oe, panel_addr, buf_sel);
    end
    vectors++;
    if ({rd_row, rd_plane, rd_col, panel_rgb} !== 17'd0) begin
      miscompares++;
      $display("FAIL async_reset_rd: got %h required 0", {rd_row, rd_plane, rd_col, panel_rgb});
    end
    repeat (2) tick();
    @(negedge clock);
    resetn = 1'b1;
    tick();
    vectors++;
    if (frame_start !== 1'b1 || rd_row !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_after_reset: fs=%b row=%0d required 1/0", frame_start, rd_row);
    end
  endtask

  initial begin
    test_reset();
    test_shift_latch();
    test_brightness_zero();
    test_scoreboard_frame();
    test_swap();
    test_pause_resume();
    test_reset_mid_display();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
